// File: rtl/uart_rx_filt.sv
// uart_rx_filt
//   UART 8N1 receive core. Synchronises and glitch-filters the raw line,
//   recovers frames using a programmable bit-period divider and delivers
//   each byte as a single-cycle strobe. A low stop bit raises frame_err
//   instead of stb.
//
// Parameters
//   DIV_WIDTH      width of the bit-period divider
//   GLITCH_FILTER  extra consecutive cycles a new level must persist (0 = off)
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         raw serial line, idle high, asynchronous to clk
//   div        bit period minus one, in clk cycles (sampled at timer load)
//   data       last good byte; updates in the stb cycle, then held
//   stb        one-cycle pulse per byte with a valid stop bit
//   frame_err  one-cycle pulse when the stop bit samples low
module uart_rx_filt #(
  parameter int DIV_WIDTH     = 8,
  parameter int GLITCH_FILTER = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [7:0]           data,
  output logic                 stb,
  output logic                 frame_err
);

  // The counter only has to reach GLITCH_FILTER; keep at least one bit so
  // the declaration stays legal when the filter is disabled.
  localparam int GW = (GLITCH_FILTER < 1) ? 1 : $clog2(GLITCH_FILTER + 1);
  localparam logic [GW-1:0] GMAX = GW'(GLITCH_FILTER);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]           sync;
  logic                 rxs;
  logic                 rxf;
  logic                 rxf_prev;
  logic [GW-1:0]        gcnt;
  state_t               state;
  logic [DIV_WIDTH-1:0] timer;
  logic                 tick;
  logic [2:0]           bitcnt;
  logic [7:0]           shreg;

  assign rxs  = sync[1];
  assign tick = (timer == '0);

  // Two-flop synchroniser, idle-high reset so no false start leaves reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  // Glitch filter: gcnt counts consecutive cycles of disagreement. Because
  // the line is binary, a run of disagreement means rxs held one steady new
  // level, which is accepted once it has lasted GLITCH_FILTER+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf      <= 1'b1;
      rxf_prev <= 1'b1;
      gcnt     <= '0;
    end else begin
      rxf_prev <= rxf;
      if (rxs != rxf) begin
        if (gcnt == GMAX) begin
          rxf  <= rxs;
          gcnt <= '0;
        end else begin
          gcnt <= gcnt + GW'(1);
        end
      end else begin
        gcnt <= '0;
      end
    end
  end

  // Frame FSM together with the bit timer it reloads. The timer free-runs
  // (reloading div on every tick); the FSM overrides the reload only on a
  // start edge, where the first sample must land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      data      <= '0;
      stb       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      stb       <= 1'b0;
      frame_err <= 1'b0;

      if (tick) begin
        timer <= div;
      end else begin
        timer <= timer - DIV_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          if (rxf_prev && !rxf) begin
            timer <= div >> 1;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rxf) begin
              bitcnt <= '0;
              state  <= DATA;
            end else begin
              // Line went back high before mid-bit: not a real start bit.
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            // LSB arrives first, so shifting in at the MSB leaves the byte
            // in natural order after eight bits.
            shreg  <= {rxf, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rxf) begin
              data <= shreg;
              stb  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_filt.sv
// tb_uart_rx_filt
//   Directed plus randomized bench for uart_rx_filt. The line level driven
//   in every cycle is recorded; a reference model derives the filtered line
//   from run lengths and decodes frames with the bit-centre timing formula,
//   and the resulting stb/frame_err events (cycle, kind, byte) are compared
//   with what the DUT produced.
module tb_uart_rx_filt;

  localparam int GF = 2;

  typedef struct {
    int         cyc;
    bit         kind;   // 0 = stb, 1 = frame_err
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] div = 8'd3;
  logic [7:0] data;
  logic       stb;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  bit         pin_q[$];
  logic [7:0] div_q[$];
  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         done_n = 0;
  logic [7:0] model_last = 8'h00;

  uart_rx_filt #(.DIV_WIDTH(8), .GLITCH_FILTER(GF)) dut (
    .clk(clk), .rst(rst), .rx(rx), .div(div),
    .data(data), .stb(stb), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Record line and divider per cycle, and any output event, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (stb || frame_err) begin
        obs_q.push_back(ev_t'{pin_q.size(), frame_err, data});
        chk("stb_ferr_exclusive", int'(stb && frame_err), 0);
      end
      pin_q.push_back(rx);
      div_q.push_back(div);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // v[0] goes on the line first; each symbol lasts d+1 cycles.
  task automatic drive_bits(input logic [9:0] v, input int nbits, input int d);
    for (int i = 0; i < nbits; i++) begin
      rx = v[i];
      repeat (d + 1) step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop, input int d);
    drive_bits({stop, b, 1'b0}, 10, d);
    rx = 1'b1;
  endtask

  // Reference model over the current segment (everything since reset).
  task automatic build_expected();
    int n, t, s, x, idx;
    bit rxs_a[];
    bit rxf_a[];
    bit v, all_eq, done;
    logic [7:0] b;
    logic [7:0] last;
    n = pin_q.size();
    exp_q.delete();
    last = 8'h00;
    b = 8'h00;
    if (n >= 2) begin
      rxs_a = new[n];
      rxf_a = new[n];
      for (int c = 0; c < n; c++) rxs_a[c] = (c >= 2) ? pin_q[c-2] : 1'b1;
      // A new level is adopted once it has been seen GF+1 cycles in a row.
      rxf_a[0] = 1'b1;
      for (int c = 1; c < n; c++) begin
        v = rxs_a[c-1];
        all_eq = 1'b1;
        for (int j = 0; j <= GF; j++) begin
          idx = c - 1 - j;
          if (idx >= 0) begin
            if (rxs_a[idx] != v) all_eq = 1'b0;
          end else if (v != 1'b1) begin
            all_eq = 1'b0;
          end
        end
        rxf_a[c] = (all_eq && v != rxf_a[c-1]) ? v : rxf_a[c-1];
      end
      t = 1;
      done = 1'b0;
      while (!done && t < n) begin
        if (rxf_a[t-1] && !rxf_a[t]) begin
          s = t + (int'(div_q[t]) >> 1) + 1;
          if (s >= n) begin
            done = 1'b1;
          end else if (rxf_a[s]) begin
            t = s + 1;
          end else begin
            x = s;
            for (int k = 0; k < 8; k++) begin
              if (!done) begin
                x = x + int'(div_q[x]) + 1;
                if (x >= n) done = 1'b1;
                else b[k] = rxf_a[x];
              end
            end
            if (!done) begin
              x = x + int'(div_q[x]) + 1;
              if (x + 1 >= n) begin
                done = 1'b1;
              end else begin
                if (rxf_a[x]) begin
                  exp_q.push_back(ev_t'{x + 1, 1'b0, b});
                  last = b;
                end else begin
                  exp_q.push_back(ev_t'{x + 1, 1'b1, last});
                end
                t = x + 1;
              end
            end
          end
        end else begin
          t++;
        end
      end
    end
    model_last = last;
  endtask

  task automatic run_check(input string tag);
    build_expected();
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = done_n; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_kind"}, int'(obs_q[i].kind), int'(exp_q[i].kind));
      chk({tag, "_data"}, int'(obs_q[i].d), int'(exp_q[i].d));
    end
    chk({tag, "_held"}, int'(data), int'(model_last));
    done_n = obs_q.size();
  endtask

  initial begin
    int p, k0, d;
    logic [7:0] rb;
    bit rstop;

    // Reset and first segment.
    repeat (3) step();
    chk("rst_data", int'(data), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_ferr", int'(frame_err), 0);
    rst = 1'b0;
    idle(10);
    run_check("idle");

    // 0x55 at div=3: stb lands where the timing formula says.
    div = 8'd3;
    k0 = obs_q.size();
    p = pin_q.size();
    send_byte(8'h55, 1'b1, 3);
    idle(20);
    run_check("b55");
    chk("b55_seen", int'(obs_q.size() > k0), 1);
    if (obs_q.size() > k0) begin
      chk("b55_formula_cycle", obs_q[k0].cyc, p + 5 + (3 >> 1) + 1 + 9 * 4 + 1);
      chk("b55_value", int'(obs_q[k0].d), 8'h55);
    end

    // A 2-cycle glitch just before a frame must not disturb its timing.
    div = 8'd7;
    idle(20);
    rx = 1'b0; repeat (2) step();
    rx = 1'b1; repeat (2) step();
    send_byte(8'h96, 1'b1, 7);
    idle(40);
    run_check("glitch2");

    // A 3-cycle pulse is accepted and swallows the frame edge that follows.
    div = 8'd15;
    idle(20);
    rx = 1'b0; repeat (3) step();
    rx = 1'b1; repeat (4) step();
    send_byte(8'h5A, 1'b1, 15);
    idle(200);
    run_check("pulse3");

    // False start: low for 5 cycles at div=15, then a normal frame.
    rx = 1'b0; repeat (5) step();
    idle(40);
    run_check("false_start");
    send_byte(8'h81, 1'b1, 15);
    idle(40);
    run_check("after_false");

    // Low stop bit: frame_err only, data keeps previous byte.
    d = $urandom_range(12, 4);
    div = 8'(d);
    idle(5);
    send_byte(8'hA3, 1'b0, d);
    idle(3 * (d + 1));
    run_check("ferr");
    chk("ferr_data_kept", int'(data), 8'h81);

    // Back-to-back 0x00 then 0xFF with no gap.
    d = $urandom_range(20, 3);
    div = 8'(d);
    idle(30);
    k0 = obs_q.size();
    send_byte(8'h00, 1'b1, d);
    send_byte(8'hFF, 1'b1, d);
    idle(3 * (d + 1));
    run_check("b2b");
    chk("b2b_two", int'(obs_q.size() >= k0 + 2), 1);
    if (obs_q.size() >= k0 + 2) begin
      chk("b2b_spacing", obs_q[k0+1].cyc - obs_q[k0].cyc, 10 * (d + 1));
    end

    // Randomized frames, gaps, stop bits and idle glitches.
    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(20, 2);
      div = 8'(d);
      if ($urandom_range(3, 0) == 0) begin
        idle(4);
        rx = 1'b0;
        repeat ($urandom_range(4, 1)) step();
        idle(2 * d + 10);
      end
      rb = 8'($urandom);
      rstop = ($urandom_range(4, 0) != 0);
      send_byte(rb, rstop, d);
      idle($urandom_range(3 * d, 0));
    end
    idle(250);
    run_check("random");

    // Reset during data bit 4, then a clean 0x3C.
    div = 8'd7;
    idle(10);
    drive_bits({1'b1, 8'hC6, 1'b0}, 5, 7);
    rx = 1'b0;
    repeat (4) step();
    run_check("pre_rst");
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_stb", int'(stb), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    pin_q.delete();
    div_q.delete();
    obs_q.delete();
    done_n = 0;
    repeat (2) step();
    rst = 1'b0;
    idle(30);
    run_check("post_rst_idle");
    send_byte(8'h3C, 1'b1, 7);
    idle(40);
    run_check("b3c");
    chk("b3c_data", int'(data), 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_filt.md
# uart_rx_filt

UART receive core for the Wishbone UART peripheral. Sits between the `uart_rx` pad and the peripheral's RX FIFO. It synchronises and glitch-filters the line, recovers 8N1 frames using a programmable bit divider shared with the TX core, and delivers each byte as a one-cycle strobe. Framing errors are flagged separately.

## Interface
Parameters:
- `DIV_WIDTH`, default 8: width of the bit-period divider.
- `GLITCH_FILTER`, default 2: number of extra consecutive cycles a new line level must persist before it is accepted. 0 disables the filter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `div`  in  DIV_WIDTH  bit period minus one, in `clk` cycles.
- `data`  out  8  last received byte; valid when `stb` is high, then held.
- `stb`  out  1  one-cycle pulse when a byte with a valid stop bit is received.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- Synchroniser: 2 flops, both reset to 1. Output is `rxs`.
- Glitch filter:
  - Filtered level `rxf` resets to 1, together with a saturating counter `gcnt`.
  - When `rxs != rxf`, `gcnt` increments. When `rxs == rxf`, `gcnt` clears.
  - When `rxs != rxf` and `gcnt == GLITCH_FILTER`, `rxf` takes `rxs` and `gcnt` clears.
  - Net effect: a new level must be present for GLITCH_FILTER+1 consecutive cycles.
  - With GLITCH_FILTER=0, `rxf` follows `rxs` with 1 cycle delay.
- Bit timer:
  - DIV_WIDTH-bit down-counter. `tick` is asserted when it reaches 0, and it reloads `div` on that cycle.
  - Loading value L produces `tick` L+1 cycles later, so the bit period is `div`+1 cycles.
  - `div` is sampled only at load. A change mid-frame takes effect at the next reload.
- FSM (state resets to IDLE):
  - IDLE: falling edge on `rxf` (prev 1, now 0) → load timer with `div>>1`, go to START.
  - START: on `tick`, if `rxf`==0, load `div`, clear bit counter, go to DATA. Otherwise it is a false start: go to IDLE, no output.
  - DATA: on each `tick`, shift `rxf` into the MSB of the shift register (LSB-first on the line) and increment the 3-bit bit counter. After the 8th bit, go to STOP.
  - STOP: on `tick`:
    - If `rxf`==1: copy the shift register to `data`, pulse `stb`.
    - If `rxf`==0: pulse `frame_err`, leave `data` unchanged.
    - Either way, go to IDLE.
- After a framing error or a break, a new frame needs a fresh 1→0 edge on `rxf`. A line held low never retriggers.
- No buffering: the consumer must accept `stb` in the cycle it is asserted. Dropping on full is the consumer's responsibility.

## Timing
- Reset values: `data`=0x00, `stb`=0, `frame_err`=0, state IDLE, synchroniser and `rxf` at 1, timer and counters at 0.
- Pin-to-`rxf` latency: 2 (synchroniser) + 1 + GLITCH_FILTER cycles. That is 5 cycles at the default.
- Let T0 be the cycle in which `rxf` first reads 0.
  - Start sample at T0+(`div`>>1)+1.
  - Data bit k (k=0..7) sampled at T0+(`div`>>1)+1+(k+1)(`div`+1).
  - Stop bit sampled at T0+(`div`>>1)+1+9(`div`+1).
- `stb`/`frame_err` are registered: high for exactly the cycle after the stop sample. `data` updates in that same cycle.
- Back-to-back frames: the FSM is in IDLE one cycle after the stop sample. A start edge arriving half a bit period after the stop-bit centre is accepted.
- `stb` and `frame_err` are never high together.
- Reset mid-frame: all state returns to its reset value immediately. No `stb` is produced for the partial frame.
- Minimum `div` is 1. For `div`=0, the start sample equals T0+1; behaviour is defined but not guaranteed to decode correctly.

## Test plan
- 8N1 `0x55`, `div`=3, GLITCH_FILTER=2 (4 cycles/bit) → one `stb`, `data`=0x55, at the cycle given by the Timing formula. `frame_err` stays 0.
- Low glitch of 2 cycles on idle `rx`, GLITCH_FILTER=2 → `rxf` stays 1, FSM stays IDLE, no `stb`. A 3-cycle low pulse → `rxf` toggles.
- False start: `div`=15, `rx` low for 5 cycles then high → FSM returns to IDLE at the start sample, no `stb`, no `frame_err`.
- Byte `0xA3` with stop bit driven low, then line high → one `frame_err` pulse, no `stb`, `data` keeps the previous value.
- Back-to-back `0x00` then `0xFF` with no idle gap → two `stb` pulses, 10(`div`+1) cycles apart, `data`=0x00 then 0xFF.
- Assert `rst` during data bit 4, release, then send `0x3C` → no `stb` for the aborted frame, then `stb` with `data`=0x3C.
